// File: rtl/cplx_pkg.sv
// Shared definitions for the complex ALU: opcodes, FSM state encoding and a
// generic signed saturator usable at any component width up to MAX_W.
package cplx_pkg;

   localparam logic [3:0] OP_A    = 4'd0;
   localparam logic [3:0] OP_B    = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_CMUL = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_DIV  = 4'd6;
   localparam logic [3:0] OP_CONJ = 4'd7;
   localparam logic [3:0] OP_EQ   = 4'd8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam int MAX_W = 64;
   localparam int WIDE  = 2 * MAX_W + 2;

   typedef struct packed {
      logic             ovf;
      logic [MAX_W-1:0] val;
   } sat_t;

   // Clamp a wide signed value into w-bit two's complement; val holds the
   // result sign-extended, the caller keeps the low w bits.
   function automatic sat_t sat_w(input logic signed [WIDE-1:0] x, input int w);
      logic signed [WIDE-1:0] hi;
      logic signed [WIDE-1:0] lo;
      sat_t r;
      hi    = (WIDE'(1) << (w - 1)) - WIDE'(1);
      lo    = ~hi;
      r.ovf = 1'b0;
      r.val = x[MAX_W-1:0];
      if (x > hi) begin
         r.ovf = 1'b1;
         r.val = hi[MAX_W-1:0];
      end else if (x < lo) begin
         r.ovf = 1'b1;
         r.val = lo[MAX_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fx_div_seq.sv
// Unsigned restoring divider: N-bit dividend by W-bit divisor, one quotient
// bit per clock; the start edge already performs the first iteration.
module fx_div_seq #(
   parameter int W = 32,
   parameter int N = 48
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic         done
);
   localparam int CW = $clog2(N + 1);

   logic [W-1:0]  rem;
   logic [W-1:0]  den;
   logic [CW-1:0] cnt;

   logic [W-1:0]  rem_in;
   logic [W-1:0]  den_in;
   logic [N-1:0]  quo_in;
   logic [W:0]    trial;
   logic [W-1:0]  rem_next;
   logic          q_bit;

   // quotient doubles as the dividend shift register
   always_comb begin
      rem_in   = start ? '0 : rem;
      den_in   = start ? divisor : den;
      quo_in   = start ? dividend : quotient;
      trial    = {rem_in, quo_in[N-1]};
      rem_next = trial[W-1:0];
      q_bit    = 1'b0;
      if (trial >= {1'b0, den_in}) begin
         rem_next = W'(trial - {1'b0, den_in});
         q_bit    = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rem      <= '0;
         den      <= '0;
         quotient <= '0;
         cnt      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= rem_next;
            den      <= divisor;
            quotient <= {quo_in[N-2:0], q_bit};
            cnt      <= CW'(N - 1);
         end else if (cnt != '0) begin
            rem      <= rem_next;
            quotient <= {quo_in[N-2:0], q_bit};
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1)) done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cplx_alu_seq.sv
// Fixed-point complex ALU with rounding, saturation and sequential division
// behind a start/busy/done handshake.
module cplx_alu_seq
   import cplx_pkg::*;
#(
   parameter int W    = 32,
   parameter int FRAC = 16
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [3:0]     opr,
   input  logic [2*W-1:0] inA,
   input  logic [2*W-1:0] inB,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] outAB,
   output logic           ovf,
   output logic           divz
);
   localparam int N = W + FRAC;
   localparam logic signed [WIDE-1:0] RND = WIDE'(1) << (FRAC - 1);

   logic [1:0]            state;
   logic signed [W-1:0]   a_re, a_im, b_re, b_im;
   logic signed [2*W:0]   p_re, p_im;
   logic signed [W-1:0]   in_a_re, in_a_im, in_b_re, in_b_im;
   logic signed [2*W-1:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [2*W:0]   prod_re_next, prod_im_next;
   logic signed [WIDE-1:0] f_re, f_im, pr_w, pi_w, pr_rnd, pi_rnd;
   sat_t                  f_sat_re, f_sat_im, m_sat_re, m_sat_im;
   logic [N-1:0]          q_re, q_im;
   logic                  re_done, im_done, div_start;
   logic [W+1:0]          d_re, d_im;

   function automatic logic signed [WIDE-1:0] sx(input logic signed [W-1:0] v);
      return {{(WIDE-W){v[W-1]}}, v};
   endfunction

   function automatic logic signed [2*W-1:0] sx2(input logic signed [W-1:0] v);
      return {{W{v[W-1]}}, v};
   endfunction

   function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
      logic [W-1:0] u;
      u = v;
      return v[W-1] ? (~u + W'(1)) : u;
   endfunction

   // Returns {divz, ovf, value} for one component of the divide.
   function automatic logic [W+1:0] div_fix(input logic signed [W-1:0] num,
                                            input logic signed [W-1:0] den,
                                            input logic [N-1:0] q);
      logic signed [WIDE-1:0] qs;
      sat_t s;
      logic [W+1:0] r;
      qs = {{(WIDE-N){1'b0}}, q};
      if (num[W-1] ^ den[W-1]) qs = -qs;
      s = sat_w(qs, W);
      r = {1'b0, s.ovf, s.val[W-1:0]};
      if (den == '0) begin
         r[W+1] = 1'b1;
         r[W]   = 1'b0;
         if (num == '0)      r[W-1:0] = '0;
         else if (num[W-1])  r[W-1:0] = {1'b1, {(W-1){1'b0}}};
         else                r[W-1:0] = {1'b0, {(W-1){1'b1}}};
      end
      return r;
   endfunction

   assign in_a_re = inA[2*W-1:W];
   assign in_a_im = inA[W-1:0];
   assign in_b_re = inB[2*W-1:W];
   assign in_b_im = inB[W-1:0];
   assign busy    = (state != ST_IDLE);

   // Products are formed straight from the inputs so the capture edge loads them.
   assign m_rr = sx2(in_a_re) * sx2(in_b_re);
   assign m_ii = sx2(in_a_im) * sx2(in_b_im);
   assign m_ri = sx2(in_a_re) * sx2(in_b_im);
   assign m_ir = sx2(in_a_im) * sx2(in_b_re);
   assign prod_re_next = (opr == OP_CMUL) ? {m_rr[2*W-1], m_rr} - {m_ii[2*W-1], m_ii}
                                          : {m_rr[2*W-1], m_rr};
   assign prod_im_next = (opr == OP_CMUL) ? {m_ri[2*W-1], m_ri} + {m_ir[2*W-1], m_ir}
                                          : {m_ii[2*W-1], m_ii};

   always_comb begin
      f_re = '0;
      f_im = '0;
      case (opr)
         OP_A:    begin f_re = sx(in_a_re);                f_im = sx(in_a_im); end
         OP_B:    begin f_re = sx(in_b_re);                f_im = sx(in_b_im); end
         OP_ADD:  begin f_re = sx(in_a_re) + sx(in_b_re);  f_im = sx(in_a_im) + sx(in_b_im); end
         OP_SUB:  begin f_re = sx(in_a_re) - sx(in_b_re);  f_im = sx(in_a_im) - sx(in_b_im); end
         OP_CONJ: begin f_re = sx(in_a_re);                f_im = -sx(in_a_im); end
         OP_EQ:   if (inA == inB) begin f_re = sx(in_a_re); f_im = sx(in_a_im); end
         default: ;
      endcase
   end

   always_comb begin
      pr_w   = {{(WIDE-2*W-1){p_re[2*W]}}, p_re};
      pi_w   = {{(WIDE-2*W-1){p_im[2*W]}}, p_im};
      pr_rnd = (pr_w + RND) >>> FRAC;
      pi_rnd = (pi_w + RND) >>> FRAC;
   end

   assign f_sat_re = sat_w(f_re, W);
   assign f_sat_im = sat_w(f_im, W);
   assign m_sat_re = sat_w(pr_rnd, W);
   assign m_sat_im = sat_w(pi_rnd, W);
   assign d_re     = div_fix(a_re, b_re, q_re);
   assign d_im     = div_fix(a_im, b_im, q_im);
   assign div_start = start && (state == ST_IDLE) && (opr == OP_DIV);

   fx_div_seq #(.W(W), .N(N)) u_div_re (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend ({mag(in_a_re), {FRAC{1'b0}}}),
      .divisor  (mag(in_b_re)),
      .quotient (q_re),
      .done     (re_done)
   );

   fx_div_seq #(.W(W), .N(N)) u_div_im (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend ({mag(in_a_im), {FRAC{1'b0}}}),
      .divisor  (mag(in_b_im)),
      .quotient (q_im),
      .done     (im_done)
   );

   // Single-cycle opcodes finish on the capture edge; MUL finishes one edge
   // later, DIV hands over to FIN once both dividers report done.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         outAB <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         divz  <= 1'b0;
         a_re  <= '0;
         a_im  <= '0;
         b_re  <= '0;
         b_im  <= '0;
         p_re  <= '0;
         p_im  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_re <= in_a_re;
                  a_im <= in_a_im;
                  b_re <= in_b_re;
                  b_im <= in_b_im;
                  p_re <= prod_re_next;
                  p_im <= prod_im_next;
                  if (opr == OP_CMUL || opr == OP_MUL) begin
                     state <= ST_MUL;
                  end else if (opr == OP_DIV) begin
                     state <= ST_DIV;
                  end else begin
                     outAB <= {f_sat_re.val[W-1:0], f_sat_im.val[W-1:0]};
                     ovf   <= f_sat_re.ovf | f_sat_im.ovf;
                     divz  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               outAB <= {m_sat_re.val[W-1:0], m_sat_im.val[W-1:0]};
               ovf   <= m_sat_re.ovf | m_sat_im.ovf;
               divz  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            ST_DIV: begin
               if (re_done && im_done) state <= ST_FIN;
            end
            default: begin
               outAB <= {d_re[W-1:0], d_im[W-1:0]};
               ovf   <= d_re[W] | d_im[W];
               divz  <= d_re[W+1] | d_im[W+1];
               done  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cplx_alu_seq.sv
// Self-checking bench for cplx_alu_seq at W=32, FRAC=16: directed vectors,
// handshake/reset scenarios and random operations against a plain-arithmetic model.
module tb_cplx_alu_seq;

   localparam int W    = 32;
   localparam int FRAC = 16;
   typedef logic signed [127:0] big_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  opr;
   logic [63:0] inA, inB, outAB;
   logic        busy, done, ovf, divz;

   int          tests = 0;
   int          failed = 0;

   logic [63:0] er, hA, hB, ra, rb;
   logic        eo, ed, busy_ok;
   logic [31:0] im_part;
   logic [3:0]  rop;
   int          el, n_done, done_at;

   always #5 clock = ~clock;

   cplx_alu_seq #(.W(W), .FRAC(FRAC)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .opr   (opr),
      .inA   (inA),
      .inB   (inB),
      .busy  (busy),
      .done  (done),
      .outAB (outAB),
      .ovf   (ovf),
      .divz  (divz)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic big_t comp(input logic [31:0] x);
      logic signed [31:0] s;
      s = x;
      return s;
   endfunction

   function automatic void sat32(input big_t v, output logic [31:0] r, output logic o);
      big_t hi, lo;
      hi = 128'sh7fffffff;
      lo = -128'sh80000000;
      o  = 1'b0;
      r  = v[31:0];
      if (v > hi) begin r = 32'h7fffffff; o = 1'b1; end
      else if (v < lo) begin r = 32'h80000000; o = 1'b1; end
   endfunction

   function automatic void div1(input logic [31:0] n, input logic [31:0] d,
                                output logic [31:0] r, output logic o, output logic z);
      big_t nn, dd, an, ad, q;
      nn = comp(n);
      dd = comp(d);
      o = 1'b0;
      z = 1'b0;
      if (dd == 0) begin
         z = 1'b1;
         if (nn == 0)     r = 32'h0;
         else if (nn < 0) r = 32'h80000000;
         else             r = 32'h7fffffff;
      end else begin
         an = (nn < 0) ? -nn : nn;
         ad = (dd < 0) ? -dd : dd;
         q  = (an * 65536) / ad;
         if ((nn < 0) != (dd < 0)) q = -q;
         sat32(q, r, o);
      end
   endfunction

   // Reference: result, ovf, divz and edge count (capture edge included) to done.
   function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output logic o, output logic z, output int lat);
      big_t ar, ai, br, bi, vr, vi;
      logic [31:0] rr, ri;
      logic o1, o2, z1, z2;
      ar = comp(a[63:32]); ai = comp(a[31:0]);
      br = comp(b[63:32]); bi = comp(b[31:0]);
      vr = 0; vi = 0; lat = 1; z1 = 1'b0; z2 = 1'b0;
      case (op)
         4'd0: begin vr = ar; vi = ai; end
         4'd1: begin vr = br; vi = bi; end
         4'd2: begin vr = ar + br; vi = ai + bi; end
         4'd3: begin vr = ar - br; vi = ai - bi; end
         4'd4: begin vr = ar * br - ai * bi; vi = ar * bi + ai * br; lat = 2; end
         4'd5: begin vr = ar * br; vi = ai * bi; lat = 2; end
         4'd7: begin vr = ar; vi = -ai; end
         4'd8: if (a == b) begin vr = ar; vi = ai; end
         default: ;
      endcase
      if (op == 4'd4 || op == 4'd5) begin
         vr = (vr + 32768) >>> FRAC;
         vi = (vi + 32768) >>> FRAC;
      end
      if (op == 4'd6) begin
         div1(a[63:32], b[63:32], rr, o1, z1);
         div1(a[31:0], b[31:0], ri, o2, z2);
         lat = W + FRAC + 2;
      end else begin
         sat32(vr, rr, o1);
         sat32(vi, ri, o2);
      end
      res = {rr, ri};
      o   = o1 | o2;
      z   = z1 | z2;
   endfunction

   function automatic logic [31:0] rand_comp();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0: v = 32'h0;
         1: v = 32'h7fffffff;
         2: v = 32'h80000000;
         3, 4, 5: begin v = $urandom_range(0, 32'h3ffff); v = v - 32'h20000; end
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issues one operation, scrambles the inputs after capture and checks it.
   task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input string tag);
      logic [63:0] x_res;
      logic x_o, x_z, b_ok;
      int x_lat, lat;
      model(op, a, b, x_res, x_o, x_z, x_lat);
      @(negedge clock);
      start = 1'b1; opr = op; inA = a; inB = b;
      lat = 0;
      b_ok = 1'b1;
      do begin
         @(posedge clock); #1;
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            inA = {$urandom, $urandom};
            inB = {$urandom, $urandom};
         end
         if (!done && !busy) b_ok = 1'b0;
      end while (!done && lat < 100);
      checkOutput({tag, " latency"}, 64'(lat), 64'(x_lat));
      checkOutput({tag, " outAB"}, outAB, x_res);
      checkOutput({tag, " ovf"}, 64'(ovf), 64'(x_o));
      checkOutput({tag, " divz"}, 64'(divz), 64'(x_z));
      checkOutput({tag, " busy"}, 64'({b_ok, busy}), 64'(2'b10));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opr = 4'd0; inA = '0; inB = '0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset outAB", outAB, 64'h0);
      checkOutput("reset done", 64'(done), 64'h0);
      checkOutput("reset busy", 64'(busy), 64'h0);
      checkOutput("reset ovf", 64'(ovf), 64'h0);
      checkOutput("reset divz", 64'(divz), 64'h0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus(4'd2, 64'h00010000_00020000, 64'h00008000_FFFF0000, "add");
      checkOutput("add value", outAB, 64'h00018000_00010000);
      @(posedge clock); #1;
      checkOutput("done pulse width", 64'(done), 64'h0);

      applyStimulus(4'd4, 64'h00010000_00020000, 64'h00030000_00040000, "cmul");
      checkOutput("cmul value", outAB, 64'hFFFB0000_000A0000);

      applyStimulus(4'd6, 64'h00030000_00010000, 64'h00020000_00040000, "div");
      checkOutput("div value", outAB, 64'h00018000_00004000);

      applyStimulus(4'd6, 64'hFFFF0000_00000000, 64'h0, "divzero");
      checkOutput("divzero value", outAB, 64'h80000000_00000000);
      checkOutput("divzero flag", 64'(divz), 64'h1);

      applyStimulus(4'd2, 64'h7FFF0000_80000000, 64'h00010000_00000000, "sat add");
      checkOutput("sat add value", outAB, 64'h7FFFFFFF_80000000);
      checkOutput("sat add ovf", 64'(ovf), 64'h1);

      applyStimulus(4'd7, 64'h7FFF0000_80000000, 64'h0, "conj");
      im_part = outAB[31:0];
      checkOutput("conj im", 64'(im_part), 64'h7FFFFFFF);

      // A second request while dividing must be ignored.
      hA = 64'h00030000_00010000;
      hB = 64'h00020000_00040000;
      model(4'd6, hA, hB, er, eo, ed, el);
      @(negedge clock);
      start = 1'b1; opr = 4'd6; inA = hA; inB = hB;
      n_done = 0; done_at = 0; busy_ok = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clock); #1;
         if (k == 1) start = 1'b0;
         if (k == 4) begin start = 1'b1; opr = 4'd2; inA = {$urandom, $urandom}; inB = {$urandom, $urandom}; end
         if (k == 5) start = 1'b0;
         if (done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (k < 50 && !busy) busy_ok = 1'b0;
      end
      checkOutput("ignore start done count", 64'(n_done), 64'd1);
      checkOutput("ignore start done edge", 64'(done_at), 64'(el));
      checkOutput("ignore start outAB", outAB, er);
      checkOutput("ignore start busy", 64'(busy_ok), 64'h1);

      // Reset partway through a divide aborts it.
      @(negedge clock);
      start = 1'b1; opr = 4'd6; inA = hA; inB = hB;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clock); #1;
         if (k == 1) start = 1'b0;
         if (k == 19) reset = 1'b1;
      end
      checkOutput("abort outAB", outAB, 64'h0);
      checkOutput("abort done", 64'(done), 64'h0);
      checkOutput("abort busy", 64'(busy), 64'h0);
      checkOutput("abort ovf", 64'(ovf), 64'h0);
      checkOutput("abort divz", 64'(divz), 64'h0);
      reset = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clock); #1;
         if (done) n_done++;
      end
      checkOutput("abort no done", 64'(n_done), 64'h0);
      applyStimulus(4'd2, 64'h00010000_00020000, 64'h00008000_FFFF0000, "post reset add");

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = {rand_comp(), rand_comp()};
         rb  = {rand_comp(), rand_comp()};
         if (rop == 4'd8 && $urandom_range(0, 1) == 1) rb = ra;
         applyStimulus(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/cplx_alu_seq.md
# cplx_alu_seq

Parametrised fixed-point complex ALU, the successor to the single-width complex ALU. Each operand packs a real and an imaginary part, both two's-complement Q(W−FRAC).FRAC. The block adds rounding, saturation, and sequential component-wise division behind a start/busy/done handshake. It sits between the operand register file and the result writeback. Modulus and angle are handled by the separate sqrt/CORDIC path and are not part of this block.

## Interface
- W, 32, width of each component (real, imag); must be ≥ 8
- FRAC, 16, fraction bits per component; 1 ≤ FRAC < W
- clock  in  1  master clock, posedge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- opr  in  4  opcode, sampled with start
- inA  in  2W  {re[2W−1:W], im[W−1:0]}, sampled with start
- inB  in  2W  same packing, sampled with start
- busy  out  1  high from the edge accepting start until the edge raising done
- done  out  1  one-cycle pulse; outAB valid from this cycle on
- outAB  out  2W  result, held until the next done
- ovf  out  1  saturation occurred in the last result; valid with done, held
- divz  out  1  zero divisor in the last result; valid with done, held

## Operation
- Opcodes:
  - 0: A
  - 1: B
  - 2: A+B
  - 3: A−B
  - 4: A·B complex multiply: re = ReA·ReB − ImA·ImB; im = ReA·ImB + ImA·ReB
  - 5: component multiply {ReA·ReB, ImA·ImB}
  - 6: component divide {ReA/ReB, ImA/ImB}
  - 7: conj(A) = {ReA, −ImA}
  - 8: equality test, result {A} if A==B, else 0
  - 9–15: illegal; result 0, ovf=0, divz=0
- Operands are captured into internal registers when start is accepted. The inputs may change afterwards.
- Add, subtract and negate use W+1-bit intermediates. Results saturate to [−2^(W−1), 2^(W−1)−1].
- Multiply:
  - Full 2W-bit signed products.
  - Complex sums use 2W+1 bits.
  - Then add 2^(FRAC−1) (round half up), arithmetic shift right by FRAC, and saturate to W bits.
- Divide:
  - Per component, the quotient is (|num|·2^FRAC)/|den|, truncated toward zero, with the sign applied afterwards. Then saturate to W bits.
  - If den==0: result is 0 when num==0; otherwise max positive or max negative, following the sign of num. divz=1; ovf is unaffected by this case.
- Negating −2^(W−1) (conj) saturates to 2^(W−1)−1 and sets ovf.
- ovf is the OR of saturation across both components.
- FSM states:
  - IDLE: on accepted start, capture operands. Go to MUL for opcodes 4/5, DIV for opcode 6, otherwise FIN.
  - MUL: one product-register cycle, then go to FIN.
  - DIV: run N=W+FRAC iterations, then go to FIN.
  - FIN: round, saturate and register outAB/ovf/divz, pulse done, return to IDLE.
- For single-cycle opcodes, the FIN work happens in the capture edge itself. No separate FIN cycle is spent.

## Timing
- Reset values: outAB=0, done=0, busy=0, ovf=0, divz=0; FSM goes to IDLE.
- Latency is counted from the edge that samples start to the edge that raises done:
  - opcodes 0–3 and 7–15: 1
  - opcodes 4–5: 2
  - opcode 6: W+FRAC+2 (50 at the defaults)
- start while busy=1 is ignored: no queueing and no effect on the current operation.
- busy is low in the done cycle, so start may be asserted in the done cycle and is accepted at the next edge (back-to-back issue).
- Reset during any state aborts the operation: no done, outputs return to their reset values.
- For opcode 6, both component divisions run concurrently and finish on the same edge.

## Structure
- Shared package/header cplx_pkg holds:
  - opcode localparams (OP_A … OP_EQ)
  - the FSM state encoding
  - a saturate-to-W function
- One sub-module, fx_div_seq: W-bit unsigned restoring divider with start/done and an N-cycle iteration count. It is instantiated twice, for the real and imaginary components.
- Sign handling, zero-divisor detection and saturation stay in cplx_alu_seq.

## Test plan
(All scenarios use W=32, FRAC=16.)
- Add:
  - A=0x00010000_00020000, B=0x00008000_FFFF0000, opr=2.
  - Expect outAB=0x00018000_00010000 at latency 1; ovf=0.
- Complex multiply:
  - A=0x00010000_00020000, B=0x00030000_00040000, opr=4.
  - Expect outAB=0xFFFB0000_000A0000 at latency 2.
- Component divide:
  - A=0x00030000_00010000, B=0x00020000_00040000, opr=6.
  - Expect outAB=0x00018000_00004000 with done exactly 50 edges after start; busy high throughout.
- Divide by zero:
  - A=0xFFFF0000_00000000, B=0x0_0, opr=6.
  - Expect outAB=0x80000000_00000000, divz=1.
- Saturation:
  - A=0x7FFF0000_80000000, B=0x00010000_00000000, opr=2.
  - Expect outAB=0x7FFFFFFF_80000000, ovf=1.
  - Then opr=7 with the same A: expect im=0x7FFFFFFF, ovf=1.
- Handshake and reset:
  - Start opr=6, pulse start opr=2 at cycle 5: the second request is ignored and a single done is seen at cycle 50.
  - Repeat and assert reset at cycle 20: no done, all outputs 0.
  - A new add issued next is correct at latency 1.
